// File: rtl/mem_access_sequencer.sv
// Multicycle load/store sequencer sitting between the datapath and a single-port data memory.
// Loads extract and zero-extend; partial stores do read-modify-write with exactly one write cycle.

module mem_access_sequencer_chk (
   input logic        clk,
   input logic        reset,
   input logic        mem_wr,
   input logic        busy,
   input logic        done,
   input logic        err,
   input logic [31:0] mem_wdata
);
   a_wr_busy:    assert property (@(posedge clk) disable iff (!reset) mem_wr |-> busy);
   a_wr_done:    assert property (@(posedge clk) disable iff (!reset) !(mem_wr && done));
   a_err_done:   assert property (@(posedge clk) disable iff (!reset) err |-> done);
   a_wdata_zero: assert property (@(posedge clk) disable iff (!reset) !mem_wr |-> (mem_wdata == 32'h0000_0000));
   a_done_pulse: assert property (@(posedge clk) disable iff (!reset) done |=> !done);
   a_wr_pulse:   assert property (@(posedge clk) disable iff (!reset) mem_wr |=> !mem_wr);
endmodule

module mem_access_sequencer #(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic [31:0] load_data,
   output logic        busy,
   output logic        done,
   output logic        err
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [1:0] SZ_WORD  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_BYTE  = 2'b10;
   localparam logic [1:0] SZ_RSVD  = 2'b11;
   localparam logic [2:0] OP_SW    = 3'b100;
   localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 32'd1);

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic [2:0]  op_r;
   logic [31:0] addr_r;
   logic [31:0] sdata_r;
   logic [31:0] wdata_r;
   logic [31:0] load_r;
   logic        wr_r;
   logic        busy_r;
   logic        done_r;
   logic        err_r;

   function automatic logic [31:0] extract_load(input logic [1:0] size, input logic [31:0] rdata);
      logic [31:0] res;
      case (size)
         SZ_HALF: res = {16'h0000, rdata[15:0]};
         SZ_BYTE: res = {24'h00_0000, rdata[7:0]};
         SZ_WORD: res = rdata;
         default: res = rdata;
      endcase
      return res;
   endfunction

   // Upper bits come from the word read back; only the addressed low part is replaced.
   function automatic logic [31:0] merge_store(input logic [1:0] size, input logic [31:0] rword,
                                               input logic [31:0] sdata);
      logic [31:0] res;
      case (size)
         SZ_HALF: res = {rword[31:16], sdata[15:0]};
         SZ_BYTE: res = {rword[31:8], sdata[7:0]};
         SZ_WORD: res = sdata;
         default: res = sdata;
      endcase
      return res;
   endfunction

   // Access FSM; every output is registered and set on the edge entering its state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_IDLE;
         cnt_r   <= 4'd0;
         op_r    <= 3'd0;
         addr_r  <= 32'h0000_0000;
         sdata_r <= 32'h0000_0000;
         wdata_r <= 32'h0000_0000;
         load_r  <= 32'h0000_0000;
         wr_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               done_r  <= 1'b0;
               err_r   <= 1'b0;
               wr_r    <= 1'b0;
               wdata_r <= 32'h0000_0000;
               cnt_r   <= 4'd0;
               if (start) begin
                  op_r    <= op;
                  addr_r  <= addr;
                  sdata_r <= store_data;
                  busy_r  <= 1'b1;
                  if (op[1:0] == SZ_RSVD) begin
                     state_r <= S_DONE;
                     done_r  <= 1'b1;
                     err_r   <= 1'b1;
                  end else if (op == OP_SW) begin
                     state_r <= S_WR;
                     wr_r    <= 1'b1;
                     wdata_r <= store_data;
                  end else begin
                     state_r <= S_RD;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            S_RD: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= 4'd0;
                  state_r <= S_CAP;
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            S_CAP: begin
               // mem_rdata is only trusted in this cycle
               if (op_r[2]) begin
                  state_r <= S_WR;
                  wr_r    <= 1'b1;
                  wdata_r <= merge_store(op_r[1:0], mem_rdata, sdata_r);
               end else begin
                  state_r <= S_DONE;
                  done_r  <= 1'b1;
                  load_r  <= extract_load(op_r[1:0], mem_rdata);
               end
            end
            S_WR: begin
               wr_r    <= 1'b0;
               wdata_r <= 32'h0000_0000;
               done_r  <= 1'b1;
               state_r <= S_DONE;
            end
            S_DONE: begin
               done_r  <= 1'b0;
               err_r   <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
               cnt_r   <= 4'd0;
               wr_r    <= 1'b0;
               wdata_r <= 32'h0000_0000;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               err_r   <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr  = addr_r;
   assign mem_wr    = wr_r;
   assign mem_wdata = wdata_r;
   assign load_data = load_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;

   mem_access_sequencer_chk u_chk (
      .clk       (clk),
      .reset     (reset),
      .mem_wr    (wr_r),
      .busy      (busy_r),
      .done      (done_r),
      .err       (err_r),
      .mem_wdata (wdata_r)
   );
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench: MEM_LAT=1 instance against a one-word memory model, MEM_LAT=3 instance with
// bench-driven read data that is only valid during the capture cycle.

module tb_mem_access_sequencer;
   logic        clk = 1'b0;
   logic        reset;
   logic        start1;
   logic        start2;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] store_data;

   logic [31:0] mem_rdata1, mem_addr1, mem_wdata1, load_data1;
   logic        mem_wr1, busy1, done1, err1;
   logic [31:0] rdata2, mem_addr2, mem_wdata2, load_data2;
   logic        mem_wr2, busy2, done2, err2;

   logic [31:0] mem1;
   logic        mem_set;
   logic [31:0] mem_set_val;
   int          wr_cnt1 = 0;
   int          wr_cnt2 = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_access_sequencer #(.MEM_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .op(op), .addr(addr), .store_data(store_data),
      .mem_rdata(mem_rdata1), .mem_addr(mem_addr1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1),
      .load_data(load_data1), .busy(busy1), .done(done1), .err(err1)
   );

   mem_access_sequencer #(.MEM_LAT(3)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .op(op), .addr(addr), .store_data(store_data),
      .mem_rdata(rdata2), .mem_addr(mem_addr2), .mem_wr(mem_wr2), .mem_wdata(mem_wdata2),
      .load_data(load_data2), .busy(busy2), .done(done2), .err(err2)
   );

   assign mem_rdata1 = (mem_addr1 == 32'h0000_0040) ? mem1 : 32'hBAD0_BAD0;

   // One-word memory model at 0x40 plus write counters
   always @(posedge clk) begin
      if (mem_wr1) begin
         mem1    <= mem_wdata1;
         wr_cnt1 <= wr_cnt1 + 1;
      end else if (mem_set) begin
         mem1 <= mem_set_val;
      end
      if (mem_wr2) wr_cnt2 <= wr_cnt2 + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One access on dut1; cycle numbers count edges since the accepting edge.
   task automatic access1(input logic [2:0] o, input logic [31:0] sd, input bit hold,
                          output int dcyc, output int nwr, output int wcyc,
                          output logic [31:0] wdat, output logic e, output int wz_bad);
      op = o; addr = 32'h0000_0040; store_data = sd; start1 = 1'b1;
      dcyc = -1; nwr = 0; wcyc = -1; wdat = 32'h0000_0000; e = 1'b0; wz_bad = 0;
      tick;
      if (!hold) begin
         start1 = 1'b0; op = 3'b011; addr = 32'h0000_0000; store_data = 32'h5A5A_5A5A;
      end
      for (int i = 1; i <= 24; i++) begin
         if (mem_wr1) begin
            nwr++; wcyc = i; wdat = mem_wdata1;
         end else if (mem_wdata1 !== 32'h0000_0000) begin
            wz_bad++;
         end
         if (done1) begin
            dcyc = i; e = err1;
            break;
         end
         tick;
      end
      start1 = 1'b0;
      tick;
   endtask

   int          dc, nw, wc, wb, snap;
   logic [31:0] wd;
   logic        e;

   initial begin
      reset = 1'b1; start1 = 1'b0; start2 = 1'b0; op = 3'b000; addr = 32'h0; store_data = 32'h0;
      rdata2 = 32'h0; mem_set = 1'b1; mem_set_val = 32'hAABB_CCDD;
      #2 reset = 1'b0;
      #1;
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_err", 32'(err1), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr1), 32'd0);
      chk("rst_load_data", load_data1, 32'h0000_0000);
      tick; tick;
      mem_set = 1'b0; reset = 1'b1;
      tick;

      access1(3'b000, 32'h0, 1'b0, dc, nw, wc, wd, e, wb);
      chk("lw_done_cycle", 32'(dc), 32'd3);
      chk("lw_data", load_data1, 32'hAABB_CCDD);
      chk("lw_writes", 32'(nw), 32'd0);
      chk("lw_err", 32'(e), 32'd0);
      chk("lw_busy_after", 32'(busy1), 32'd0);

      access1(3'b001, 32'h0, 1'b0, dc, nw, wc, wd, e, wb);
      chk("lh_done_cycle", 32'(dc), 32'd3);
      chk("lh_data", load_data1, 32'h0000_CCDD);
      chk("lh_writes", 32'(nw), 32'd0);

      access1(3'b010, 32'h0, 1'b0, dc, nw, wc, wd, e, wb);
      chk("lb_done_cycle", 32'(dc), 32'd3);
      chk("lb_data", load_data1, 32'h0000_00DD);
      chk("lb_writes", 32'(nw), 32'd0);

      access1(3'b101, 32'h1122_3344, 1'b0, dc, nw, wc, wd, e, wb);
      chk("sh_done_cycle", 32'(dc), 32'd4);
      chk("sh_writes", 32'(nw), 32'd1);
      chk("sh_write_cycle", 32'(wc), 32'd3);
      chk("sh_wdata", wd, 32'hAABB_3344);
      chk("sh_wdata_idle_zero", 32'(wb), 32'd0);
      chk("sh_mem", mem1, 32'hAABB_3344);
      chk("sh_load_kept", load_data1, 32'h0000_00DD);

      mem_set_val = 32'hAABB_CCDD; mem_set = 1'b1;
      tick;
      mem_set = 1'b0;
      access1(3'b110, 32'h1122_3344, 1'b0, dc, nw, wc, wd, e, wb);
      chk("sb_done_cycle", 32'(dc), 32'd4);
      chk("sb_writes", 32'(nw), 32'd1);
      chk("sb_wdata", wd, 32'hAABB_CC44);
      chk("sb_mem", mem1, 32'hAABB_CC44);

      access1(3'b100, 32'hDEAD_BEEF, 1'b0, dc, nw, wc, wd, e, wb);
      chk("sw_done_cycle", 32'(dc), 32'd2);
      chk("sw_writes", 32'(nw), 32'd1);
      chk("sw_write_cycle", 32'(wc), 32'd1);
      chk("sw_wdata", wd, 32'hDEAD_BEEF);
      chk("sw_mem", mem1, 32'hDEAD_BEEF);
      chk("sw_wdata_idle_zero", 32'(wb), 32'd0);

      snap = wr_cnt1;
      access1(3'b011, 32'h0, 1'b0, dc, nw, wc, wd, e, wb);
      chk("rsvd_done_cycle", 32'(dc), 32'd1);
      chk("rsvd_err", 32'(e), 32'd1);
      chk("rsvd_writes", 32'(wr_cnt1 - snap), 32'd0);
      chk("rsvd_load_kept", load_data1, 32'h0000_00DD);
      chk("rsvd_err_cleared", 32'(err1), 32'd0);

      // accepted in the very first IDLE cycle after the previous done
      access1(3'b010, 32'h0, 1'b0, dc, nw, wc, wd, e, wb);
      chk("b2b_lb_done_cycle", 32'(dc), 32'd3);
      chk("b2b_lb_data", load_data1, 32'h0000_00EF);

      access1(3'b000, 32'h0, 1'b1, dc, nw, wc, wd, e, wb);
      chk("hold_lw_done_cycle", 32'(dc), 32'd3);
      chk("hold_lw_data", load_data1, 32'hDEAD_BEEF);
      chk("hold_lw_err", 32'(e), 32'd0);
      tick; tick;
      chk("hold_idle_busy", 32'(busy1), 32'd0);
      chk("hold_idle_done", 32'(done1), 32'd0);

      mem_set_val = 32'hAABB_CCDD; mem_set = 1'b1;
      tick;
      mem_set = 1'b0;
      op = 3'b110; addr = 32'h0000_0040; store_data = 32'h1122_3344; start1 = 1'b1;
      tick;
      start1 = 1'b0;
      tick; tick;
      chk("rst_sb_in_wr", 32'(mem_wr1), 32'd1);
      chk("rst_sb_wdata", mem_wdata1, 32'hAABB_CC44);
      snap = wr_cnt1;
      #2 reset = 1'b0;
      #1;
      chk("rst_async_mem_wr", 32'(mem_wr1), 32'd0);
      chk("rst_async_busy", 32'(busy1), 32'd0);
      chk("rst_async_wdata", mem_wdata1, 32'h0000_0000);
      tick; tick;
      reset = 1'b1;
      tick; tick;
      chk("rst_release_busy", 32'(busy1), 32'd0);
      chk("rst_release_mem", mem1, 32'hAABB_CCDD);
      chk("rst_release_writes", 32'(wr_cnt1 - snap), 32'd0);
      chk("rst_release_load", load_data1, 32'h0000_0000);

      op = 3'b001; addr = 32'h0000_0040; store_data = 32'h0; start2 = 1'b1; rdata2 = 32'h1234_5678;
      tick;
      start2 = 1'b0; op = 3'b000; rdata2 = 32'h9999_8888;
      tick; tick;
      chk("lat3_c3_done", 32'(done2), 32'd0);
      tick;
      chk("lat3_c4_done", 32'(done2), 32'd0);
      chk("lat3_c4_busy", 32'(busy2), 32'd1);
      rdata2 = 32'hAABB_CCDD;
      tick;
      chk("lat3_c5_done", 32'(done2), 32'd1);
      chk("lat3_lh_data", load_data2, 32'h0000_CCDD);
      rdata2 = 32'hFFFF_FFFF;
      tick;
      chk("lat3_idle_busy", 32'(busy2), 32'd0);
      chk("lat3_load_kept", load_data2, 32'h0000_CCDD);
      chk("lat3_writes", 32'(wr_cnt2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
